fifo_in_reader: RTL and testbench

//  Drain side of the 285-bit command FIFO (fifo_in): pops one entry at a time, splits it into
//  {cmd, addr, data} and presents it to the DDR controller port with valid/ready handshakes.

---
 rtl/fifo_in_reader_pkg.sv | 33 +++
 rtl/fifo_in_reader_outst_counter.sv | 43 ++++
 rtl/fifo_in_reader.sv | 127 ++++++++++++
 tb/tb_fifo_in_reader.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_in_reader_pkg.sv
// Shared definitions for the fifo_in drain side: entry layout, widths and FSM encoding.
package fifo_pkg;

    localparam int ADDR_W   = 28;
    localparam int DATA_W   = 256;
    localparam int ENTRY_W  = 1 + ADDR_W + DATA_W;
    localparam int CNT_W    = 4;

    localparam int WR_BIT   = ENTRY_W - 1;
    localparam int ADDR_MSB = WR_BIT - 1;
    localparam int ADDR_LSB = DATA_W;
    localparam int DATA_MSB = DATA_W - 1;
    localparam int DATA_LSB = 0;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        POP   = 3'd1,
        LATCH = 3'd2,
        CMD   = 3'd3,
        WDATA = 3'd4
    } state_t;

    // Pulls the address field out of a raw fifo_in entry.
    function automatic logic [ADDR_W-1:0] entryAddr(input logic [ENTRY_W-1:0] entry);
        return entry[ADDR_MSB:ADDR_LSB];
    endfunction

    // Pulls the payload field out of a raw fifo_in entry.
    function automatic logic [DATA_W-1:0] entryData(input logic [ENTRY_W-1:0] entry);
        return entry[DATA_MSB:DATA_LSB];
    endfunction

endpackage

// File: rtl/fifo_in_reader_outst_counter.sv
// Up/down counter of DDR reads in flight; saturates at 0 and at MAX, flags full at MAX.
module outst_counter
    import fifo_pkg::*;
#(
    parameter int MAX = 8
)
(
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             inc_i,
    input  logic             dec_i,
    output logic [CNT_W-1:0] count_o,
    output logic             full_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Next count: simultaneous issue and return cancel out; a return at zero is ignored.
    always_comb begin
        count_d = count_q;
        if (inc_i && !dec_i && (count_q != CNT_MAX)) begin
            count_d = count_q + 1'b1;
        end else if (dec_i && !inc_i && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    // Count register, cleared by reset.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign full_o  = (count_q == CNT_MAX);

endmodule

// File: rtl/fifo_in_reader.sv
// Drains fifo_in one entry at a time and hands it to the DDR controller as a
// command (plus a write-data beat for writes), throttling reads in flight.
module fifo_in_reader
    import fifo_pkg::*;
#(
    parameter int MAX_OUTST = 8
)
(
    input  logic               clock_i,
    input  logic               reset_i,
    input  logic [ENTRY_W-1:0] q_i,
    input  logic               empty_i,
    output logic               rdEn_o,
    output logic               cmdValid_o,
    input  logic               cmdReady_i,
    output logic               cmdWr_o,
    output logic [ADDR_W-1:0]  cmdAddr_o,
    output logic               wrValid_o,
    input  logic               wrReady_i,
    output logic [DATA_W-1:0]  wrData_o,
    input  logic               rdReturn_i,
    output logic               busy_o,
    output logic [CNT_W-1:0]   outstCnt_o
);

    state_t state_q;
    state_t state_d;

    logic              cmdWr_q;
    logic [ADDR_W-1:0] cmdAddr_q;
    logic [DATA_W-1:0] wrData_q;

    logic popStrobe;
    logic cmdValid;
    logic wrValid;
    logic cntFull;
    logic readAccepted;

    // A read must wait while the controller already holds the maximum number of reads.
    // The count can only rise through this block, so a raised cmd_valid is never withdrawn.
    logic cmdStall;
    assign cmdStall = !cmdWr_q && cntFull;

    // Next-state and handshake strobes for the pop / latch / command / write-data sequence.
    always_comb begin
        state_d   = state_q;
        popStrobe = 1'b0;
        cmdValid  = 1'b0;
        wrValid   = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty_i) begin
                    state_d = POP;
                end
            end
            POP: begin
                popStrobe = 1'b1;
                state_d   = LATCH;
            end
            LATCH: begin
                state_d = CMD;
            end
            CMD: begin
                if (!cmdStall) begin
                    cmdValid = 1'b1;
                    if (cmdReady_i) begin
                        state_d = cmdWr_q ? WDATA : IDLE;
                    end
                end
            end
            WDATA: begin
                wrValid = 1'b1;
                if (wrReady_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register; reset drops whatever entry was in flight.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Capture the popped entry once fifo_in data is valid; held steady through CMD and WDATA.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            cmdWr_q   <= 1'b0;
            cmdAddr_q <= '0;
            wrData_q  <= '0;
        end else if (state_q == LATCH) begin
            cmdWr_q   <= q_i[WR_BIT];
            cmdAddr_q <= entryAddr(q_i);
            wrData_q  <= entryData(q_i);
        end
    end

    assign readAccepted = cmdValid && cmdReady_i && !cmdWr_q;

    outst_counter #(
        .MAX (MAX_OUTST)
    ) u_outstCounter (
        .clock_i (clock_i),
        .reset_i (reset_i),
        .inc_i   (readAccepted),
        .dec_i   (rdReturn_i),
        .count_o (outstCnt_o),
        .full_o  (cntFull)
    );

    // The pop strobe is suppressed while reset is held so no entry is lost on that cycle.
    assign rdEn_o     = popStrobe && !reset_i;
    assign cmdValid_o = cmdValid;
    assign wrValid_o  = wrValid;
    assign cmdWr_o    = cmdWr_q;
    assign cmdAddr_o  = cmdAddr_q;
    assign wrData_o   = wrData_q;
    assign busy_o     = (state_q != IDLE);

endmodule

// File: tb/tb_fifo_in_reader.sv
// Directed bench for fifo_in_reader: a small fifo_in model feeds entries, a scoreboard
// of pushed entries is matched against every command and write-data handshake.
module tb_fifo_in_reader;

    localparam int EW = 285;

    logic           clock;
    logic           reset_i;
    logic [EW-1:0]  q;
    logic           empty;
    logic           rdEn;
    logic           cmdValid;
    logic           cmdReady;
    logic           cmdWr;
    logic [27:0]    cmdAddr;
    logic           wrValid;
    logic           wrReady;
    logic [255:0]   wrData;
    logic           rdReturn;
    logic           busy;
    logic [3:0]     outstCnt;

    logic [EW-1:0]  fifoMem [0:63];
    int             wrPtr = 0;
    int             rdPtr = 0;

    logic [EW-1:0]  expQ [$];
    logic [EW-1:0]  wrExpQ [$];

    int vectors     = 0;
    int miscompares = 0;

    fifo_in_reader #(
        .MAX_OUTST (8)
    ) dut (
        .clock_i    (clock),
        .reset_i    (reset_i),
        .q_i        (q),
        .empty_i    (empty),
        .rdEn_o     (rdEn),
        .cmdValid_o (cmdValid),
        .cmdReady_i (cmdReady),
        .cmdWr_o    (cmdWr),
        .cmdAddr_o  (cmdAddr),
        .wrValid_o  (wrValid),
        .wrReady_i  (wrReady),
        .wrData_o   (wrData),
        .rdReturn_i (rdReturn),
        .busy_o     (busy),
        .outstCnt_o (outstCnt)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // fifo_in model: read data appears the cycle after the pop strobe.
    assign empty = (rdPtr == wrPtr);

    initial q = '0;

    always @(posedge clock) begin
        if (rdEn && (rdPtr != wrPtr)) begin
            q     <= fifoMem[rdPtr];
            rdPtr <= rdPtr + 1;
        end
    end

    task automatic checkOutput(input string tag, input logic [EW-1:0] observed,
                               input logic [EW-1:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h required=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [EW-1:0] entry);
        fifoMem[wrPtr] = entry;
        wrPtr++;
        expQ.push_back(entry);
    endtask

    // Matches handshakes seen this cycle against the scoreboard.
    task automatic scoreboardCheck();
        logic [EW-1:0] e;
        if (reset_i) begin
            wrExpQ.delete();
        end else begin
            if (cmdValid && cmdReady) begin
                if (expQ.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $error("[TB] FAIL sbCmd observed=addr %0h required=no command", cmdAddr);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("sbCmd", {cmdWr, cmdAddr, wrData}, e);
                    if (e[284]) wrExpQ.push_back(e);
                end
            end
            if (wrValid && wrReady) begin
                if (wrExpQ.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $error("[TB] FAIL sbWr observed=data %0h required=no beat", wrData);
                end else begin
                    e = wrExpQ.pop_front();
                    checkOutput("sbWrData", EW'(wrData), EW'(e[255:0]));
                end
            end
        end
    endtask

    task automatic nextNeg();
        @(negedge clock);
        scoreboardCheck();
    endtask

    task automatic toPos();
        @(posedge clock);
        #1;
    endtask

    initial begin
        logic [255:0] patA5;
        logic [255:0] pat5A;
        patA5    = {32{8'hA5}};
        pat5A    = {32{8'h5A}};
        reset_i  = 1'b1;
        cmdReady = 1'b0;
        wrReady  = 1'b0;
        rdReturn = 1'b0;

        // Reset state
        nextNeg();
        nextNeg();
        checkOutput("rstRdEn",     EW'(rdEn),     EW'(0));
        checkOutput("rstCmdValid", EW'(cmdValid), EW'(0));
        checkOutput("rstWrValid",  EW'(wrValid),  EW'(0));
        checkOutput("rstBusy",     EW'(busy),     EW'(0));
        checkOutput("rstCmdWr",    EW'(cmdWr),    EW'(0));
        checkOutput("rstCmdAddr",  EW'(cmdAddr),  EW'(0));
        checkOutput("rstWrData",   EW'(wrData),   EW'(0));
        checkOutput("rstOutst",    EW'(outstCnt), EW'(0));

        // Idle with an empty FIFO
        toPos();
        reset_i = 1'b0;
        for (int i = 0; i < 20; i++) begin
            nextNeg();
            checkOutput("idleQuiet", EW'({rdEn, cmdValid, wrValid, busy}), EW'(0));
        end

        // A stray read return at zero must not wrap the count
        toPos();
        rdReturn = 1'b1;
        nextNeg();
        toPos();
        rdReturn = 1'b0;
        nextNeg();
        checkOutput("outstSatZero", EW'(outstCnt), EW'(0));

        // Single write entry, controller always ready
        toPos();
        cmdReady = 1'b1;
        wrReady  = 1'b1;
        applyStimulus({1'b1, 28'h0000100, patA5});
        nextNeg();
        checkOutput("wrC0RdEn", EW'({rdEn, busy}), EW'(2'b00));
        nextNeg();
        checkOutput("wrC1RdEn", EW'({rdEn, busy, cmdValid}), EW'(3'b110));
        nextNeg();
        checkOutput("wrC2Latch", EW'({rdEn, cmdValid}), EW'(2'b00));
        nextNeg();
        checkOutput("wrC3Cmd", EW'({cmdValid, cmdWr, cmdAddr}), EW'({2'b11, 28'h0000100}));
        nextNeg();
        checkOutput("wrC4Valid", EW'({wrValid, cmdValid}), EW'(2'b10));
        checkOutput("wrC4Data", EW'(wrData), EW'(patA5));
        nextNeg();
        checkOutput("wrC5Idle", EW'({busy, wrValid}), EW'(2'b00));

        // Read entry with the controller stalling for 5 cycles
        toPos();
        cmdReady = 1'b0;
        applyStimulus({1'b0, 28'h0000200, pat5A});
        nextNeg();
        nextNeg();
        nextNeg();
        nextNeg();
        checkOutput("rdStallC3", EW'({cmdValid, cmdWr, cmdAddr}), EW'({2'b10, 28'h0000200}));
        for (int c = 4; c < 8; c++) begin
            nextNeg();
            checkOutput("rdStallHold", EW'({cmdValid, cmdAddr}), EW'({1'b1, 28'h0000200}));
        end
        toPos();
        cmdReady = 1'b1;
        nextNeg();
        checkOutput("rdStallC8", EW'(cmdValid), EW'(1));
        nextNeg();
        checkOutput("rdStallDone", EW'({cmdValid, busy, outstCnt}), EW'({2'b00, 4'd1}));

        // Drain the count, then nine reads against a limit of eight
        toPos();
        rdReturn = 1'b1;
        nextNeg();
        toPos();
        rdReturn = 1'b0;
        nextNeg();
        checkOutput("outstCleared", EW'(outstCnt), EW'(0));
        toPos();
        for (int k = 0; k < 9; k++) begin
            applyStimulus({1'b0, 28'(32'h1000 + k), {8{32'hC0DE0000 + k}}});
        end
        for (int c = 0; c <= 35; c++) nextNeg();
        checkOutput("maxStall", EW'({cmdValid, busy, outstCnt}), EW'({2'b01, 4'd8}));
        for (int c = 36; c < 40; c++) begin
            nextNeg();
            checkOutput("maxStallHold", EW'({cmdValid, outstCnt}), EW'({1'b0, 4'd8}));
        end
        toPos();
        rdReturn = 1'b1;
        nextNeg();
        checkOutput("maxRetC40", EW'({cmdValid, outstCnt}), EW'({1'b0, 4'd8}));
        toPos();
        rdReturn = 1'b0;
        nextNeg();
        checkOutput("maxRelease", EW'({cmdValid, cmdAddr, outstCnt}), EW'({1'b1, 28'h0001008, 4'd7}));
        nextNeg();
        checkOutput("maxRefill", EW'({cmdValid, busy, outstCnt}), EW'({2'b00, 4'd8}));

        // Return coincident with an accepted read at count 3
        for (int i = 0; i < 5; i++) begin
            toPos();
            rdReturn = 1'b1;
            nextNeg();
        end
        toPos();
        rdReturn = 1'b0;
        nextNeg();
        checkOutput("outstAt3", EW'(outstCnt), EW'(3));
        toPos();
        applyStimulus({1'b0, 28'h0000300, patA5});
        nextNeg();
        nextNeg();
        nextNeg();
        toPos();
        rdReturn = 1'b1;
        nextNeg();
        checkOutput("coincC3", EW'({cmdValid, outstCnt}), EW'({1'b1, 4'd3}));
        toPos();
        rdReturn = 1'b0;
        nextNeg();
        checkOutput("coincAfter", EW'({busy, outstCnt}), EW'({1'b0, 4'd3}));

        // Reset while stuck in the write-data phase
        toPos();
        wrReady = 1'b0;
        applyStimulus({1'b1, 28'h0000400, pat5A});
        for (int c = 0; c < 5; c++) nextNeg();
        checkOutput("rstWdataPre", EW'({wrValid, busy}), EW'(2'b11));
        toPos();
        reset_i = 1'b1;
        applyStimulus({1'b1, 28'h0000500, patA5});
        nextNeg();
        nextNeg();
        checkOutput("rstMidOp", EW'({wrValid, busy, rdEn, outstCnt}), EW'(7'b0));
        nextNeg();
        checkOutput("rstHoldNoPop", EW'({rdEn, busy}), EW'(2'b00));
        toPos();
        reset_i = 1'b0;
        wrReady = 1'b1;
        nextNeg();
        checkOutput("rstRelC0", EW'({rdEn, busy}), EW'(2'b00));
        nextNeg();
        checkOutput("rstRelPop", EW'({rdEn, busy}), EW'(2'b11));
        for (int c = 0; c < 6; c++) nextNeg();
        checkOutput("finalIdle", EW'({busy, cmdValid, wrValid}), EW'(0));
        checkOutput("sbCmdDrained", EW'(expQ.size()), EW'(0));
        checkOutput("sbWrDrained", EW'(wrExpQ.size()), EW'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
